// File: rtl/mine_field_gen.sv
// Mine field builder: places NUM_MINES mines away from the first click and
// computes per-tile neighbour counts, then holds the board with game_ready.
module mine_field_gen #(
  parameter int          GRID_SIZE     = 8,
  parameter int          TOTAL_TILES   = GRID_SIZE * GRID_SIZE,
  parameter int          NUM_MINES     = 10,
  parameter int          EXCLUDE_NEIGH = 1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  localparam int         INDEX_BITS    = $clog2(TOTAL_TILES),
  localparam int         COUNT_BITS    = $clog2(TOTAL_TILES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [INDEX_BITS-1:0]      start_index,
  output logic [TOTAL_TILES-1:0]     mine_map,
  output logic [TOTAL_TILES*4-1:0]   adj,
  output logic [COUNT_BITS-1:0]      mine_count,
  output logic                       game_ready
);

  localparam logic [COUNT_BITS-1:0] MINES_C = COUNT_BITS'(NUM_MINES);

  typedef enum logic [1:0] {IDLE, PLACE, ADJ, READY} state_e;

  state_e                          state_q, state_d;
  logic [15:0]                     lfsr_q, lfsr_d;
  logic [INDEX_BITS-1:0]           idx0_q, idx0_d;
  logic [TOTAL_TILES-1:0]          mine_map_q, mine_map_d;
  logic [TOTAL_TILES-1:0][3:0]     adj_q, adj_d;
  logic [COUNT_BITS-1:0]           count_q, count_d;
  logic [INDEX_BITS-1:0]           tile_q, tile_d;
  logic                            ready_q, ready_d;

  logic [INDEX_BITS-1:0]           cand;
  logic                            cand_ok;
  logic [3:0]                      nbr_sum;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign cand   = lfsr_q[INDEX_BITS-1:0];

  // Candidate is rejected if off-board, already a mine, or inside the safe zone
  always_comb begin : cand_check
    int cr, cc, sr, sc, dr, dc;
    cr = int'(cand) / GRID_SIZE;
    cc = int'(cand) % GRID_SIZE;
    sr = int'(idx0_q) / GRID_SIZE;
    sc = int'(idx0_q) % GRID_SIZE;
    dr = (cr > sr) ? (cr - sr) : (sr - cr);
    dc = (cc > sc) ? (cc - sc) : (sc - cc);
    cand_ok = 1'b1;
    if (int'(cand) >= TOTAL_TILES) begin
      cand_ok = 1'b0;
    end else if (mine_map_q[cand]) begin
      cand_ok = 1'b0;
    end else if (cand == idx0_q) begin
      cand_ok = 1'b0;
    end else if (EXCLUDE_NEIGH != 0 && dr <= 1 && dc <= 1) begin
      cand_ok = 1'b0;
    end
  end

  always_comb begin : nbr_count
    int tr, tc, r, c;
    logic [INDEX_BITS-1:0] nidx;
    tr = int'(tile_q) / GRID_SIZE;
    tc = int'(tile_q) % GRID_SIZE;
    nbr_sum = 4'd0;
    nidx = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        r = tr + dr;
        c = tc + dc;
        if (!(dr == 0 && dc == 0) && r >= 0 && r < GRID_SIZE && c >= 0 && c < GRID_SIZE) begin
          nidx = INDEX_BITS'(r * GRID_SIZE + c);
          nbr_sum = nbr_sum + {3'b000, mine_map_q[nidx]};
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx0_d     = idx0_q;
    mine_map_d = mine_map_q;
    adj_d      = adj_q;
    count_d    = count_q;
    tile_d     = tile_q;
    ready_d    = ready_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx0_d     = start_index;
          mine_map_d = '0;
          count_d    = '0;
          tile_d     = '0;
          state_d    = (NUM_MINES == 0) ? ADJ : PLACE;
        end
      end
      PLACE: begin
        if (cand_ok) begin
          mine_map_d[cand] = 1'b1;
          count_d          = count_q + 1'b1;
          if (count_q + 1'b1 == MINES_C) begin
            state_d = ADJ;
            tile_d  = '0;
          end
        end
      end
      ADJ: begin
        adj_d[tile_q] = mine_map_q[tile_q] ? 4'hF : nbr_sum;
        if (int'(tile_q) == TOTAL_TILES - 1) begin
          state_d = READY;
          ready_d = 1'b1;
        end else begin
          tile_d = tile_q + 1'b1;
        end
      end
      READY: begin
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      lfsr_q     <= LFSR_SEED;
      idx0_q     <= '0;
      mine_map_q <= '0;
      adj_q      <= '0;
      count_q    <= '0;
      tile_q     <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      idx0_q     <= idx0_d;
      mine_map_q <= mine_map_d;
      adj_q      <= adj_d;
      count_q    <= count_d;
      tile_q     <= tile_d;
      ready_q    <= ready_d;
    end
  end

  assign mine_map   = mine_map_q;
  assign adj        = adj_q;
  assign mine_count = count_q;
  assign game_ready = ready_q;

endmodule

// File: tb/tb_mine_field_gen.sv
// Directed bench for mine_field_gen: predicts placement from an LFSR model
// and checks latency, mine map, neighbour counts, safe zone and reset.
module tb_mine_field_gen;

  localparam int GRID  = 8;
  localparam int TILES = 64;
  localparam int MINES = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         startZ = 1'b0;
  logic [5:0]   startIndex = '0;
  logic [5:0]   startIndexZ = '0;
  logic [63:0]  mineMap, mineMapZ;
  logic [255:0] adj, adjZ;
  logic [6:0]   mineCount, mineCountZ;
  logic         gameReady, gameReadyZ;
  logic [15:0]  mLfsr;

  int compared = 0;
  int mismatched = 0;

  mine_field_gen #(.GRID_SIZE(8), .NUM_MINES(10), .EXCLUDE_NEIGH(1), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start(start), .start_index(startIndex),
    .mine_map(mineMap), .adj(adj), .mine_count(mineCount), .game_ready(gameReady)
  );

  mine_field_gen #(.GRID_SIZE(8), .NUM_MINES(0), .EXCLUDE_NEIGH(1), .LFSR_SEED(16'hACE1)) dut_z (
    .clk(clk), .rst(rst), .start(startZ), .start_index(startIndexZ),
    .mine_map(mineMapZ), .adj(adjZ), .mine_count(mineCountZ), .game_ready(gameReadyZ)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsrStep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference LFSR tracking the free-running generator inside the DUT
  always @(posedge clk or negedge rst) begin
    if (!rst) mLfsr <= 16'hACE1;
    else      mLfsr <= lfsrStep(mLfsr);
  end

  function automatic bit inBlock(input int a, input int b);
    int dr, dc;
    dr = a / GRID - b / GRID;
    dc = a % GRID - b % GRID;
    if (dr < 0) dr = -dr;
    if (dc < 0) dc = -dc;
    return (dr <= 1 && dc <= 1);
  endfunction

  function automatic logic [63:0] blockMask(input int idx);
    logic [63:0] m;
    m = '0;
    for (int t = 0; t < TILES; t++)
      if (inBlock(t, idx)) m[t] = 1'b1;
    return m;
  endfunction

  function automatic void modelPlace(input logic [15:0] seed, input int idx,
                                     output logic [63:0] map, output int p);
    logic [15:0] l;
    int cnt, cand;
    l = seed;
    cnt = 0;
    map = '0;
    p = 0;
    while (cnt < MINES && p < 5000) begin
      l = lfsrStep(l);
      p++;
      cand = int'(l[5:0]);
      if (!map[cand] && !inBlock(cand, idx)) begin
        map[cand] = 1'b1;
        cnt++;
      end
    end
  endfunction

  function automatic logic [255:0] modelAdj(input logic [63:0] map);
    logic [63:0][3:0] res;
    int r, c, n;
    for (int t = 0; t < TILES; t++) begin
      n = 0;
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++) begin
          r = t / GRID + dr;
          c = t % GRID + dc;
          if (!(dr == 0 && dc == 0) && r >= 0 && r < GRID && c >= 0 && c < GRID)
            if (map[6'(r * GRID + c)]) n++;
        end
      res[t] = map[t] ? 4'hF : 4'(n);
    end
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // One full build from start to game_ready, optionally poking start mid-build
  task automatic applyStimulus(input int idx, input int pulsePlace, input int pulseAdjOff,
                               input bit pulseReady, input string name);
    logic [63:0] expMap;
    logic [255:0] expAdj;
    int p, cyc, adjAt;
    bit ready;
    modelPlace(mLfsr, idx, expMap, p);
    expAdj = modelAdj(expMap);
    adjAt = (pulseAdjOff > 0) ? p + pulseAdjOff : -1;
    startIndex = 6'(idx);
    start = 1'b1;
    cyc = 0;
    ready = 1'b0;
    while (!ready && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == pulsePlace || cyc == adjAt);
      ready = gameReady;
    end
    start = 1'b0;
    checkOutput({name, "/latency"}, 256'(cyc), 256'(1 + p + 64));
    checkOutput({name, "/mine_map"}, 256'(mineMap), 256'(expMap));
    checkOutput({name, "/mine_count"}, 256'(mineCount), 256'(MINES));
    checkOutput({name, "/popcount"}, 256'($countones(mineMap)), 256'(MINES));
    checkOutput({name, "/safe_zone"}, 256'(mineMap & blockMask(idx)), 256'(0));
    checkOutput({name, "/adj_all"}, adj, expAdj);
    checkOutput({name, "/adj_click"}, 256'(adj[idx*4 +: 4]), 256'(0));
    checkOutput({name, "/adj_corner0"}, 256'(adj[3:0]), 256'(expAdj[3:0]));
    checkOutput({name, "/adj_corner63"}, 256'(adj[255:252]), 256'(expAdj[255:252]));
    if (pulseReady) begin
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput({name, "/ready_frozen_map"}, 256'(mineMap), 256'(expMap));
      checkOutput({name, "/ready_frozen_adj"}, adj, expAdj);
      checkOutput({name, "/ready_held"}, 256'(gameReady), 256'(1));
    end
  endtask

  initial begin
    logic [63:0] map27, t6Map;
    int p, cyc;
    bit sawReady;

    // T1: reset values and idle hold
    #1 rst = 1'b0;
    #10;
    checkOutput("t1/mine_map", 256'(mineMap), 256'(0));
    checkOutput("t1/adj", adj, 256'(0));
    checkOutput("t1/mine_count", 256'(mineCount), 256'(0));
    checkOutput("t1/game_ready", 256'(gameReady), 256'(0));
    checkOutput("t1/game_ready_z", 256'(gameReadyZ), 256'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    sawReady = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (gameReady) sawReady = 1'b1;
    end
    checkOutput("t1/hold_no_ready", 256'(sawReady), 256'(0));

    // T2/T3/T5: click at 27 with stray start pulses in PLACE, ADJ and READY
    applyStimulus(27, 3, 20, 1'b1, "t2");
    map27 = '0;
    map27[18] = 1'b1; map27[19] = 1'b1; map27[20] = 1'b1;
    map27[26] = 1'b1; map27[27] = 1'b1; map27[28] = 1'b1;
    map27[34] = 1'b1; map27[35] = 1'b1; map27[36] = 1'b1;
    checkOutput("t2/hand_safe_zone", 256'(mineMap & map27), 256'(0));

    // T4: corner clicks
    pulseReset();
    repeat (7) @(posedge clk);
    #1;
    applyStimulus(63, 0, 0, 1'b0, "t4_63");
    checkOutput("t4_63/hand_safe", 256'(mineMap & 64'hC0C0_0000_0000_0000), 256'(0));
    pulseReset();
    repeat (13) @(posedge clk);
    #1;
    applyStimulus(0, 0, 0, 1'b0, "t4_0");
    checkOutput("t4_0/hand_safe", 256'(mineMap & 64'h0000_0000_0000_0303), 256'(0));

    // T6: reset in the middle of the neighbour pass, then rebuild
    pulseReset();
    repeat (3) @(posedge clk);
    #1;
    modelPlace(mLfsr, 40, t6Map, p);
    startIndex = 6'd40;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (p + 10) @(posedge clk);
    #1;
    checkOutput("t6/not_ready_mid_adj", 256'(gameReady), 256'(0));
    checkOutput("t6/map_mid_adj", 256'(mineMap), 256'(t6Map));
    rst = 1'b0;
    #2;
    checkOutput("t6/rst_mine_map", 256'(mineMap), 256'(0));
    checkOutput("t6/rst_adj", adj, 256'(0));
    checkOutput("t6/rst_mine_count", 256'(mineCount), 256'(0));
    checkOutput("t6/rst_game_ready", 256'(gameReady), 256'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    applyStimulus(40, 0, 0, 1'b1, "t6");

    // T7: zero-mine instance skips placement entirely
    pulseReset();
    startIndexZ = 6'd9;
    startZ = 1'b1;
    cyc = 0;
    sawReady = 1'b0;
    while (!sawReady && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      startZ = 1'b0;
      sawReady = gameReadyZ;
    end
    checkOutput("t7/latency", 256'(cyc), 256'(65));
    checkOutput("t7/mine_map", 256'(mineMapZ), 256'(0));
    checkOutput("t7/adj", adjZ, 256'(0));
    checkOutput("t7/mine_count", 256'(mineCountZ), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
